// File: rtl/affine_ctrl_3d.sv
// Three-deep affine loop-nest sequencer: after a flush it strobes valid once
// per II cycles while walking ctrl_vars over E0 x E1 x E2 in row-major order.
module affine_ctrl_3d #(
    parameter int unsigned E0          = 1,
    parameter int unsigned E1          = 64,
    parameter int unsigned E2          = 64,
    parameter int unsigned START_DELAY = 0,
    parameter int unsigned II          = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    output logic             valid,
    output logic [2:0][15:0] ctrl_vars,
    output logic             last,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} state_t;

    localparam logic [15:0] MAX0     = 16'(E0 - 1);
    localparam logic [15:0] MAX1     = 16'(E1 - 1);
    localparam logic [15:0] MAX2     = 16'(E2 - 1);
    localparam logic [31:0] PH_LAST  = 32'(II - 1);
    localparam logic [31:0] DLY_LAST = 32'(START_DELAY) - 32'd1;

    state_t           state, state_n;
    logic [31:0]      phase, phase_n, base_phase;
    logic [31:0]      dcnt, dcnt_n;
    logic [2:0][15:0] idx, idx_n, base_idx;
    logic             run_now, issue, at_end, wrap2, wrap1;

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        dcnt_n     = dcnt;
        idx_n      = idx;
        base_idx   = idx;
        base_phase = phase;
        run_now    = 1'b0;
        issue      = 1'b0;

        // A flush restarts from index 0; with no delay the flush cycle itself
        // may issue iteration 0 so the first strobe lands one cycle later.
        if (flush) begin
            base_idx   = '0;
            base_phase = '0;
            idx_n      = '0;
            phase_n    = '0;
            dcnt_n     = '0;
            state_n    = (START_DELAY > 0) ? DELAY : RUN;
            run_now    = (START_DELAY == 0) && !stall;
        end else if (!stall) begin
            case (state)
                DELAY: begin
                    if (dcnt == DLY_LAST) begin
                        state_n = RUN;
                        run_now = 1'b1;
                    end else begin
                        dcnt_n = dcnt + 32'd1;
                    end
                end
                RUN:     run_now = 1'b1;
                default: ;
            endcase
        end

        wrap2  = (base_idx[2] == MAX2);
        wrap1  = (base_idx[1] == MAX1);
        at_end = wrap2 && wrap1 && (base_idx[0] == MAX0);

        if (run_now) begin
            if (base_phase == '0) begin
                issue    = 1'b1;
                idx_n[2] = wrap2 ? 16'd0 : base_idx[2] + 16'd1;
                idx_n[1] = !wrap2 ? base_idx[1] : (wrap1 ? 16'd0 : base_idx[1] + 16'd1);
                idx_n[0] = !(wrap2 && wrap1) ? base_idx[0] :
                           ((base_idx[0] == MAX0) ? 16'd0 : base_idx[0] + 16'd1);
                phase_n  = (II > 1) ? 32'd1 : 32'd0;
                if (at_end) state_n = DONE;
            end else begin
                phase_n = (base_phase == PH_LAST) ? 32'd0 : base_phase + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            dcnt      <= '0;
            idx       <= '0;
            valid     <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
            ctrl_vars <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            dcnt  <= dcnt_n;
            idx   <= idx_n;
            valid <= issue;
            last  <= issue && at_end;
            // done trails the final strobe by one cycle
            done  <= !flush && (state == DONE);
            if (flush || issue) ctrl_vars <= base_idx;
        end
    end

endmodule

// File: tb/tb_affine_ctrl_3d.sv
// Scoreboard bench: four differently parameterised sequencers share one
// stimulus stream; a schedule model predicts every strobe and the done flag.
`timescale 1ns/1ps
module tb_affine_ctrl_3d;

    localparam int NI = 4;

    typedef struct {
        int unsigned      cyc;
        logic [2:0][15:0] ix;
        logic             lst;
    } ev_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    logic stall = 1'b0;

    logic             v  [NI];
    logic             l  [NI];
    logic             d  [NI];
    logic [2:0][15:0] cv [NI];

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    ev_t              sb        [NI][$];
    bit               act       [NI];
    bit               done_set  [NI];
    int unsigned      steps     [NI];
    int unsigned      jn        [NI];
    int unsigned      done_from [NI];
    logic [2:0][15:0] hold      [NI];

    always #5 clk = ~clk;

    // config table: field 0..2 = E0,E1,E2, 3 = START_DELAY, 4 = II
    function automatic int unsigned cfgv(input int i, input int f);
        int unsigned r;
        case (i)
            0:       case (f) 0: r = 1; 1: r = 64; 2: r = 64; 3: r = 0; default: r = 1; endcase
            1:       case (f) 0: r = 1; 1: r = 2;  2: r = 2;  3: r = 5; default: r = 3; endcase
            2:       case (f) 0: r = 2; 1: r = 3;  2: r = 4;  3: r = 2; default: r = 2; endcase
            default: case (f) 0: r = 3; 1: r = 1;  2: r = 2;  3: r = 0; default: r = 1; endcase
        endcase
        return r;
    endfunction

    // n-th iteration of a row-major nest
    function automatic logic [2:0][15:0] coords(input int g, input int unsigned n);
        logic [2:0][15:0] c;
        c[2] = 16'(n % cfgv(g, 2));
        c[1] = 16'((n / cfgv(g, 2)) % cfgv(g, 1));
        c[0] = 16'(n / (cfgv(g, 2) * cfgv(g, 1)));
        return c;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        affine_ctrl_3d #(
            .E0(cfgv(g, 0)), .E1(cfgv(g, 1)), .E2(cfgv(g, 2)),
            .START_DELAY(cfgv(g, 3)), .II(cfgv(g, 4))
        ) dut (
            .clk(clk), .rst(rst), .flush(flush), .stall(stall),
            .valid(v[g]), .ctrl_vars(cv[g]), .last(l[g]), .done(d[g])
        );
    end

    // Model + monitor in one process: at posedge predict, at negedge compare.
    initial begin
        int unsigned n_tot, sd, ii;
        bit          step, fire, de;
        ev_t         ev;
        forever begin
            @(posedge clk);
            for (int g = 0; g < NI; g++) begin
                n_tot = cfgv(g, 0) * cfgv(g, 1) * cfgv(g, 2);
                sd    = cfgv(g, 3);
                ii    = cfgv(g, 4);
                if (rst) begin
                    act[g]      = 1'b0;
                    done_set[g] = 1'b0;
                    hold[g]     = '0;
                end else begin
                    step = 1'b0;
                    fire = 1'b0;
                    if (flush) begin
                        act[g]      = 1'b1;
                        jn[g]       = 0;
                        done_set[g] = 1'b0;
                        hold[g]     = '0;
                        if (sd > 0) steps[g] = 1;
                        else begin
                            steps[g] = 0;
                            step     = !stall;
                        end
                    end else begin
                        step = act[g] && !stall;
                    end
                    if (step) begin
                        if (steps[g] >= sd && ((steps[g] - sd) % ii) == 0) fire = 1'b1;
                        steps[g]++;
                    end
                    if (fire) begin
                        ev.cyc  = cyc + 1;
                        ev.ix   = coords(g, jn[g]);
                        ev.lst  = (jn[g] == n_tot - 1);
                        sb[g].push_back(ev);
                        hold[g] = ev.ix;
                        jn[g]++;
                        if (jn[g] == n_tot) begin
                            act[g]       = 1'b0;
                            done_set[g]  = 1'b1;
                            done_from[g] = cyc + 2;
                        end
                    end
                end
            end
            cyc++;

            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                de = done_set[g] && (cyc >= done_from[g]);
                total++;
                if (d[g] !== de) begin
                    bad++;
                    $display("FAIL inst%0d done @%0d got=%b want=%b", g, cyc, d[g], de);
                end
                total++;
                if (cv[g] !== hold[g]) begin
                    bad++;
                    $display("FAIL inst%0d ctrl_vars @%0d got=%h want=%h", g, cyc, cv[g], hold[g]);
                end
                if (v[g] === 1'b1) begin
                    total++;
                    if (sb[g].size() == 0) begin
                        bad++;
                        $display("FAIL inst%0d unexpected valid @%0d got=1 want=0", g, cyc);
                    end else begin
                        ev = sb[g].pop_front();
                        if (ev.cyc != cyc || ev.ix !== cv[g] || ev.lst !== l[g]) begin
                            bad++;
                            $display("FAIL inst%0d iteration got @%0d idx=%h last=%b want @%0d idx=%h last=%b",
                                     g, cyc, cv[g], l[g], ev.cyc, ev.ix, ev.lst);
                        end
                    end
                end else begin
                    total++;
                    if (v[g] !== 1'b0 || l[g] !== 1'b0) begin
                        bad++;
                        $display("FAIL inst%0d strobes @%0d got valid=%b last=%b want 0/0", g, cyc, v[g], l[g]);
                    end
                    if (sb[g].size() != 0 && sb[g][0].cyc <= cyc) begin
                        total++;
                        bad++;
                        ev = sb[g].pop_front();
                        $display("FAIL inst%0d missed valid @%0d got=0 want idx=%h", g, cyc, ev.ix);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        repeat (2) @(negedge clk);
        flush = 1'b1;                       // flush together with rst
        @(negedge clk);
        flush = 1'b0;
        rst   = 1'b0;
        repeat (6) begin
            @(negedge clk);
            stall = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (4200) @(negedge clk);       // full default sweep, no stall

        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (200) @(negedge clk);
        stall = 1'b1;
        repeat (4) @(negedge clk);
        stall = 1'b0;
        repeat (4200) @(negedge clk);

        flush = 1'b1;                       // flush while stalled
        stall = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (2) @(negedge clk);
        stall = 1'b0;
        repeat (300) @(negedge clk);
        flush = 1'b1;                       // restart mid-run
        @(negedge clk);
        flush = 1'b0;

        repeat (6000) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 1499) == 0);
            flush = ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 5) == 0);
        end

        @(negedge clk);
        rst   = 1'b0;
        flush = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        repeat (4300) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/affine_ctrl_3d.md
AFFINE_CTRL_3D -- requirements
Module: affine_ctrl_3d

Interface
REQ-001 Parameter E0, default 1, extent of outermost loop index ctrl_vars[0], legal range >=1.
REQ-002 Parameter E1, default 64, extent of middle loop index ctrl_vars[1], legal range >=1.
REQ-003 Parameter E2, default 64, extent of innermost loop index ctrl_vars[2], legal range >=1.
REQ-004 Parameter START_DELAY, default 0, number of idle cycles between flush and the first iteration.
REQ-005 Parameter II, default 1, cycles between consecutive iterations, legal range >=1.
REQ-006 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 flush  input  1  single-cycle pulse that (re)starts the schedule.
REQ-009 stall  input  1  while high, freezes all schedule progress.
REQ-010 valid  output  1  iteration strobe, driven into a buffer port's wen or ren.
REQ-011 ctrl_vars  output  16 x [2:0]  current loop indices, qualified by valid.
REQ-012 last  output  1  high together with valid on the final iteration only.
REQ-013 done  output  1  high after the final iteration until the next flush or rst.

Function
REQ-014 The block SHALL implement the states IDLE, DELAY, RUN and DONE.
REQ-015 IDLE SHALL be left only on flush.
REQ-016 flush in any state SHALL zero all indices, the phase counter and the delay counter, and SHALL enter DELAY if START_DELAY>0 or RUN if START_DELAY==0.
REQ-017 DELAY SHALL count START_DELAY unstalled cycles, then enter RUN.
REQ-018 With stall low, the first valid SHALL occur exactly START_DELAY+1 cycles after the flush cycle.
REQ-019 In RUN, a phase counter SHALL cycle 0..II-1.
REQ-020 valid SHALL be high when phase==0 and stall==0, and low in all other cases.
REQ-021 Consecutive valids SHALL be spaced II cycles apart when no stall occurs.
REQ-022 On each valid, ctrl_vars[2] SHALL increment; at E2-1 it SHALL wrap to 0 and carry into ctrl_vars[1].
REQ-023 ctrl_vars[1] SHALL wrap at E1-1 and carry into ctrl_vars[0]; ctrl_vars[0] SHALL wrap at E0-1.
REQ-024 ctrl_vars SHALL show the indices of the current iteration during the valid cycle and SHALL hold that value otherwise.
REQ-025 A dimension with extent 1 SHALL hold index 0 permanently.
REQ-026 last SHALL equal valid AND all indices at their maximum (E0-1, E1-1, E2-1).
REQ-027 After the last valid, the block SHALL enter DONE, asserting done on the next cycle and holding it; no further valids SHALL occur.
REQ-028 The total number of valids per flush SHALL be E0*E1*E2.
REQ-029 stall high SHALL freeze the delay counter, phase counter, indices and state; valid and last SHALL be low while stall is high.
REQ-030 Priority SHALL be rst > flush > stall.
REQ-031 Index arithmetic SHALL be unsigned 16-bit; extents SHALL be <=65535.

Reset
REQ-032 On rst, state SHALL be IDLE and valid, last, done and ctrl_vars[0..2] SHALL all be 0.
REQ-033 rst asserted during RUN SHALL abort the schedule with no further valid until the next flush.
REQ-034 Outputs SHALL be registered; there is no combinational path from any input to any output.

Verification
REQ-035 Defaults, flush at cycle 0 -> valid on cycles 1..4096; ctrl_vars[2] sweeps 0..63 repeatedly; ctrl_vars[1] increments every 64 valids; last on cycle 4096 with indices {0,63,63}; done=1 from cycle 4097.
REQ-036 E=(1,2,2), II=3, START_DELAY=5, flush at t -> valids at t+6, t+9, t+12 and t+15 with (ctrl_vars[1],ctrl_vars[2]) = (0,0), (0,1), (1,0), (1,1); last at t+15.
REQ-037 Defaults, stall held 4 cycles mid-RUN at indices (0,3,7) -> no valid for those 4 cycles, indices unchanged; the next valid shows (0,3,8), and total valid count remains 4096.
REQ-038 flush in RUN at indices (0,10,5), START_DELAY=2 -> indices return to 0, first valid 3 cycles later at (0,0,0), done stays low.
REQ-039 rst and flush asserted in the same cycle -> IDLE; valid, last, done and ctrl_vars all 0 on the next cycle.
REQ-040 stall and flush asserted in the same cycle with START_DELAY=0 -> the schedule restarts, and the first valid occurs on the first subsequent cycle with stall low.
